// File: rtl/muldiv_controller.sv
// Multi-cycle signed MULT/DIV unit with architectural HI/LO registers.
// Sequential shift-add multiply and restoring divide on operand magnitudes, signs fixed up at the end.
module muldiv_controller #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] MULT_RUN = 3'd1;
   localparam logic [2:0] DIV_RUN  = 3'd2;
   localparam logic [2:0] FIXUP    = 3'd3;
   localparam logic [2:0] DONE     = 3'd4;

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [2:0]       state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] mag_op;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] quo;
   logic             sign_a;
   logic             sign_b;
   logic             op_div;
   logic             dbz;

   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH:0]     add_sum;
   logic [WIDTH:0]     trial;
   logic [2*WIDTH-1:0] prod_signed;
   logic [WIDTH-1:0]   quo_signed;
   logic [WIDTH-1:0]   rem_signed;

   // acc/quo hold {upper, lower} product during MULT and {remainder, dividend/quotient} during DIV.
   always_comb begin
      a_mag       = a[WIDTH-1] ? (~a + 1'b1) : a;
      b_mag       = b[WIDTH-1] ? (~b + 1'b1) : b;
      add_sum     = {1'b0, acc} + {1'b0, (quo[0] ? mag_op : '0)};
      trial       = {acc, quo[WIDTH-1]} - {1'b0, mag_op};
      prod_signed = (sign_a ^ sign_b) ? ('0 - {acc, quo}) : {acc, quo};
      quo_signed  = (sign_a ^ sign_b) ? (~quo + 1'b1) : quo;
      rem_signed  = sign_a ? (~acc + 1'b1) : acc;
   end

   assign busy        = (state != IDLE);
   assign done        = (state == DONE);
   assign div_by_zero = (state == DONE) && dbz;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= IDLE;
         cnt    <= '0;
         mag_op <= '0;
         acc    <= '0;
         quo    <= '0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         op_div <= 1'b0;
         dbz    <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start && !abort) begin
                  sign_a <= a[WIDTH-1];
                  sign_b <= b[WIDTH-1];
                  op_div <= op;
                  cnt    <= '0;
                  acc    <= '0;
                  dbz    <= 1'b0;
                  if (op && (b == '0)) begin
                     dbz   <= 1'b1;
                     state <= DONE;
                  end else begin
                     mag_op <= op ? b_mag : a_mag;
                     quo    <= op ? a_mag : b_mag;
                     state  <= op ? DIV_RUN : MULT_RUN;
                  end
               end
            end
            MULT_RUN: begin
               if (abort) begin
                  state <= IDLE;
               end else begin
                  acc <= add_sum[WIDTH:1];
                  quo <= {add_sum[0], quo[WIDTH-1:1]};
                  cnt <= cnt + 1'b1;
                  if (cnt == LAST) state <= FIXUP;
               end
            end
            DIV_RUN: begin
               if (abort) begin
                  state <= IDLE;
               end else begin
                  // A negative trial means the divisor did not fit: keep the shifted remainder.
                  if (!trial[WIDTH]) begin
                     acc <= trial[WIDTH-1:0];
                     quo <= {quo[WIDTH-2:0], 1'b1};
                  end else begin
                     acc <= {acc[WIDTH-2:0], quo[WIDTH-1]};
                     quo <= {quo[WIDTH-2:0], 1'b0};
                  end
                  cnt <= cnt + 1'b1;
                  if (cnt == LAST) state <= FIXUP;
               end
            end
            FIXUP: begin
               if (abort) begin
                  state <= IDLE;
               end else begin
                  if (op_div) begin
                     hi <= rem_signed;
                     lo <= quo_signed;
                  end else begin
                     hi <= prod_signed[2*WIDTH-1:WIDTH];
                     lo <= prod_signed[WIDTH-1:0];
                  end
                  state <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_controller.sv
// Directed self-checking bench for muldiv_controller with hand-computed results.
module tb_muldiv_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        op;
   logic [31:0] a;
   logic [31:0] b;
   logic        abort;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks   = 0;
   int failures = 0;

   muldiv_controller #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .abort(abort), .busy(busy), .done(done), .div_by_zero(div_by_zero),
      .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   // Everything is driven and sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   // Runs one normal operation and checks latency, busy span, flags and the result.
   task automatic applyStimulus(input string tag, input logic op_i, input logic [31:0] a_i,
                                input logic [31:0] b_i, input logic [63:0] exp_hilo);
      int  n;
      bit  busy_dropped;
      op    = op_i;
      a     = a_i;
      b     = b_i;
      start = 1'b1;
      tick();
      start = 1'b0;
      a     = 32'h1234_5678;
      b     = 32'h0000_0003;
      n = 1;
      busy_dropped = 1'b0;
      while (!done && n < 100) begin
         if (!busy) busy_dropped = 1'b1;
         tick();
         n++;
      end
      checkOutput({tag, " latency"}, 64'(n), 64'd34);
      checkOutput({tag, " busy held"}, 64'(busy_dropped), 64'd0);
      checkOutput({tag, " busy at done"}, 64'(busy), 64'd1);
      checkOutput({tag, " dbz"}, 64'(div_by_zero), 64'd0);
      checkOutput({tag, " hilo"}, {hi, lo}, exp_hilo);
      tick();
      checkOutput({tag, " done pulse"}, 64'(done), 64'd0);
      checkOutput({tag, " busy after"}, 64'(busy), 64'd0);
   endtask

   initial begin
      bit done_seen;
      reset = 1'b0;
      start = 1'b0;
      op    = 1'b0;
      a     = '0;
      b     = '0;
      abort = 1'b0;
      tick();
      tick();
      checkOutput("reset state", {61'(0), busy, done, div_by_zero}, 64'd0);
      checkOutput("reset hilo", {hi, lo}, 64'd0);

      // First start coincides with the first edge that sees reset released.
      reset = 1'b1;
      applyStimulus("mult 7*-3", 1'b0, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
      applyStimulus("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

      // Divide by zero: immediate done with the flag, HI/LO untouched.
      op = 1'b1; a = 32'd5; b = 32'd0; start = 1'b1;
      tick();
      start = 1'b0;
      checkOutput("dbz done", {62'(0), done, div_by_zero}, 64'd3);
      checkOutput("dbz hilo", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      tick();
      checkOutput("dbz after", {62'(0), done, busy}, 64'd0);

      applyStimulus("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000});
      applyStimulus("mult min*min", 1'b0, 32'h8000_0000, 32'h8000_0000, {32'h4000_0000, 32'h0});
      applyStimulus("div 100/7", 1'b1, 32'd100, 32'd7, {32'd2, 32'd14});
      applyStimulus("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD});
      applyStimulus("mult -5*-6", 1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 64'd30);

      // Abort together with start in IDLE must not launch anything.
      op = 1'b0; a = 32'd9; b = 32'd9; start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      checkOutput("abort beats start", 64'(busy), 64'd0);

      // Mid-flight restart is ignored, abort kills the op without a done pulse.
      op = 1'b0; a = 32'd11; b = 32'd13; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      a = 32'd2; b = 32'd3; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checkOutput("abort busy", {62'(0), busy, done}, 64'd0);
      checkOutput("abort hilo", {hi, lo}, 64'd30);
      done_seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (done || busy) done_seen = 1'b1;
         tick();
      end
      checkOutput("abort quiet", 64'(done_seen), 64'd0);
      checkOutput("abort hilo late", {hi, lo}, 64'd30);

      // Reset during DIV_RUN discards the op and clears HI/LO.
      op = 1'b1; a = 32'd1000; b = 32'd3; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (19) tick();
      reset = 1'b0;
      tick();
      checkOutput("midreset state", {62'(0), busy, done}, 64'd0);
      checkOutput("midreset hilo", {hi, lo}, 64'd0);
      reset = 1'b1;
      applyStimulus("post reset mult", 1'b0, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/muldiv_controller.md
MULDIV_CONTROLLER -- requirements
Module: muldiv_controller

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width; HI and LO are each WIDTH bits.
REQ-002 The block SHALL have a single clock, port clk, 1 bit; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit; reset is synchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit; it is the operation request, sampled only in IDLE.
REQ-005 The block SHALL have port op, input, 1 bit; 0 = MULT, 1 = DIV, both signed two's complement.
REQ-006 The block SHALL have ports a and b, input, WIDTH bits each; a is the multiplicand or dividend, b is the multiplier or divisor.
REQ-007 The block SHALL have port abort, input, 1 bit; it cancels an in-flight operation on an exception flush.
REQ-008 The block SHALL have port busy, output, 1 bit; busy = (state != IDLE).
REQ-009 The block SHALL have port done, output, 1 bit; it is a one-cycle completion pulse.
REQ-010 The block SHALL have port div_by_zero, output, 1 bit; it is valid only while done = 1.
REQ-011 The block SHALL have ports hi and lo, output, WIDTH bits each; they are the architectural HI and LO registers, driven directly from flops.

Function
REQ-012 The FSM SHALL have exactly the states IDLE, MULT_RUN, DIV_RUN, FIXUP and DONE.
REQ-013 In IDLE with start = 1 and abort = 0, edge E0 SHALL:
- capture |a|, |b|, the operand signs and op;
- clear the iteration counter;
- enter MULT_RUN or DIV_RUN.
REQ-014 MULT_RUN SHALL perform one unsigned shift-add step per cycle on the magnitudes, 32 steps in total (edges E1..E32), then enter FIXUP.
REQ-015 DIV_RUN SHALL perform one restoring-division step per cycle on the magnitudes, 32 steps in total (edges E1..E32), then enter FIXUP.
REQ-016 At FIXUP exit (edge E33), the block SHALL write hi and lo with the sign-corrected results and enter DONE.
REQ-017 In DONE, done SHALL be 1 for exactly one cycle; the next edge SHALL return the FSM to IDLE.
REQ-018 Latency: done SHALL be high in the 34th cycle after the start edge E0, i.e. the cycle following edge E33.
REQ-019 MULT result: {hi,lo} SHALL equal the full 64-bit signed product of a and b; the product is negated iff the operand signs differ.
REQ-020 DIV result:
- lo = quotient truncated toward zero;
- hi = remainder carrying the dividend's sign;
- |hi| < |b|.
REQ-021 DIV of 0x80000000 by 0xFFFFFFFF SHALL yield lo = 0x80000000 and hi = 0, with no error flag.
REQ-022 DIV with b = 0 at E0 SHALL go directly IDLE -> DONE; done = 1 and div_by_zero = 1 in the next cycle; hi and lo are unchanged.
REQ-023 div_by_zero SHALL be 0 whenever done = 0 and on every MULT.
REQ-024 start SHALL be ignored while busy = 1: no queuing and no effect on the in-flight operation.
REQ-025 Operands SHALL be captured only at E0; changes on a and b afterwards have no effect.
REQ-026 abort = 1 in any non-IDLE state SHALL force IDLE at the next edge:
- no done pulse is issued;
- hi and lo are unchanged.
REQ-027 abort = 1 together with start = 1 in IDLE: abort SHALL win and the operation SHALL NOT start.
REQ-028 abort in DONE SHALL NOT suppress the done pulse already being driven in that cycle; hi and lo were already written at E33.
REQ-029 hi and lo SHALL change only at edge E33 of a non-aborted operation or on reset.

Reset
REQ-030 On reset = 0 at a clock edge, regardless of state, the block SHALL set:
- state = IDLE;
- busy = 0, done = 0, div_by_zero = 0;
- hi = 0, lo = 0;
- the iteration counter and internal accumulators cleared.
REQ-031 reset SHALL take priority over abort and start; a reset mid-operation discards it with no done pulse.
REQ-032 The first start SHALL be accepted at the first edge with reset = 1.

Verification
REQ-033 MULT, a = 7, b = 0xFFFFFFFD (-3) -> hi = 0xFFFFFFFF, lo = 0xFFFFFFEB, done high 34 cycles after E0, busy high 34 cycles.
REQ-034 DIV, a = 0xFFFFFFF9 (-7), b = 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF, div_by_zero = 0.
REQ-035 DIV, a = 5, b = 0 -> done and div_by_zero high in the cycle after E0; hi and lo keep their prior values (e.g. from REQ-034).
REQ-036 DIV, a = 0x80000000, b = 0xFFFFFFFF -> lo = 0x80000000, hi = 0; MULT 0x80000000 × 0x80000000 -> hi = 0x40000000, lo = 0.
REQ-037 MULT started, start re-asserted at cycle 5 with new operands, abort at cycle 10 -> busy = 0 at cycle 11, no done pulse, hi and lo unchanged, second start ignored.
REQ-038 reset = 0 during DIV_RUN at cycle 20 -> next cycle busy = 0, hi = 0, lo = 0, no done pulse; a new start after reset completes normally.
